ahb_sram_slave: RTL
===================

# ahb_sram_slave

Single-clock AHB-Lite SRAM slave that terminates the sink-side master port of the AHB-to-AHB bridge. It provides the downstream memory target that bridge transactions land on. It accepts pipelined transfers, inserts a programmable number of wait states, and performs byte/halfword/word writes. It signals ERROR for out-of-range or misaligned accesses, and supports the sleep request/acknowledge handshake used across the bridge domains.

## Interface
- DATA_WIDTH, 32, data bus width; fixed at 32 because byte-lane logic assumes 4 lanes.
- ADDR_WIDTH, 32, address bus width.
- MEM_DEPTH, 256, number of 32-bit words; power of two, ≥ 2.
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15).
- i_clk  in  1  slave clock (the bridge sink clock).
- i_rstn  in  1  reset, asynchronous, active-low.
- i_hselx  in  1  slave select.
- i_htrans  in  1  1 = NONSEQ transfer, 0 = IDLE.
- i_hsize  in  3  0 = byte, 1 = halfword, 2 = word; anything else is illegal.
- i_hwrite  in  1  1 = write, 0 = read.
- i_haddr  in  ADDR_WIDTH  byte address.
- i_hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- i_hready  in  1  bus-level ready (the previous data phase is complete).
- i_sleep_req  in  1  sleep request.
- o_hreadyout  out  1  data phase complete.
- o_hresp  out  1  0 = OKAY, 1 = ERROR.
- o_hrdata  out  DATA_WIDTH  read data.
- o_sleep_ack  out  1  sleep acknowledge.

## Operation
- Address phase accepted on a rising edge where i_hselx & i_htrans & i_hready = 1.
  - At that edge, register: hwrite, hsize, haddr, and error flag.
  - The data phase starts in the next cycle.
- Error flag is set when any of the following holds:
  - word index haddr[ADDR_WIDTH-1:2] ≥ MEM_DEPTH;
  - hsize > 2;
  - hsize = 1 with haddr[0] = 1;
  - hsize = 2 with haddr[1:0] ≠ 0;
  - o_sleep_ack = 1 at the accepting edge.
- State machine: IDLE, WAIT, DONE, ERR1, ERR2.
  - IDLE: o_hreadyout = 1, o_hresp = 0. Accept with error → ERR1. Accept with WAIT_STATES = 0 → DONE. Accept with WAIT_STATES > 0 → WAIT (counter loaded with WAIT_STATES-1).
  - WAIT: o_hreadyout = 0. Counter decrements each cycle; → DONE when it reaches 0.
  - DONE: o_hreadyout = 1, o_hresp = 0. A write commits at the edge ending DONE. Accept in the same cycle → WAIT, DONE or ERR1 per the IDLE rules. Otherwise → IDLE.
  - ERR1: o_hreadyout = 0, o_hresp = 1 → ERR2. No memory access.
  - ERR2: o_hreadyout = 1, o_hresp = 1. Accept allowed here, same rules as DONE. Otherwise → IDLE.
- Writes are little-endian, lane k = hwdata[8k+7:8k].
  - Byte: only lane haddr[1:0] is written.
  - Halfword: lanes {haddr[1],0} and {haddr[1],1} are written.
  - Word: all four lanes are written.
- Reads always return the full 32-bit word; the master selects the lanes.
- o_hrdata is registered. It is loaded on the edge that enters DONE and holds until the next read loads it.
- Forwarding: a read that enters DONE on the same edge as a write commit to the same word returns the merged data (new bytes from the write, old bytes from the array).
- o_hrdata is don't-care for writes and errors; it holds its previous value.
- Sleep handshake:
  - o_sleep_ack rises on the edge where i_sleep_req = 1 and the state is IDLE with no accept on that edge.
  - o_sleep_ack falls on the first edge where i_sleep_req = 0.
  - While o_sleep_ack = 1, every accepted transfer takes the ERROR path.

## Timing
- Reset values: state IDLE, o_hreadyout = 1, o_hresp = 0, o_hrdata = 0, o_sleep_ack = 0. Memory contents are not reset.
- Reset asserted mid-operation: return to IDLE immediately. A pending write is dropped, and the wait counter is cleared.
- OKAY latency: data phase length is WAIT_STATES + 1 cycles. With WAIT_STATES = 0, back-to-back transfers run at one per cycle.
- ERROR response is always exactly 2 cycles, independent of WAIT_STATES.
- When i_hready = 0, i_hselx and i_htrans are ignored (no accept).
- Idle cycles (i_htrans = 0) while selected return OKAY with zero wait states, and the state stays IDLE.

## Test plan
- WAIT_STATES = 0: word write 0xA5A5_1234 to 0x10, then read 0x10 back-to-back.
  - Required: o_hreadyout stays 1 throughout; read DONE cycle shows o_hrdata = 0xA5A5_1234 via the forwarding path.
- WAIT_STATES = 2: word write 0xDEAD_BEEF to 0x0, then read 0x0.
  - Required: each data phase shows o_hreadyout = 0,0,1; read returns 0xDEAD_BEEF.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then word read 0x20 → 0x4433_2211.
  - Then halfword write 0xBEEF at 0x22, word read 0x20 → 0xBEEF_2211.
- Error cases, each giving o_hresp = 1 for 2 cycles with o_hreadyout = 0 then 1, and no memory change on a re-read:
  - word access to 0x402 (misaligned);
  - address MEM_DEPTH*4;
  - hsize = 3.
- Sleep: assert i_sleep_req during a WAIT_STATES = 3 write.
  - Required: o_sleep_ack rises only after DONE.
  - A transfer issued while acked → ERROR.
  - Deassert i_sleep_req → ack falls next edge; next write → OKAY.
- Assert i_rstn = 0 during WAIT of a write to 0x30 (0x30 previously 0x0).
  - Required: outputs return to reset values immediately; read of 0x30 after reset → 0x0.

Source files
------------

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM target with programmable wait states, byte-lane
//            writes, two-cycle ERROR response and sleep req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================

module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_hselx,
    input  logic                  i_htrans,
    input  logic [2:0]            i_hsize,
    input  logic                  i_hwrite,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    input  logic                  i_sleep_req,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_sleep_ack
);

    localparam int                    c_IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-3:0] c_MEM_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);
    localparam logic [3:0]            c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wcnt;
    logic [3:0]            w_wcnt_nxt;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [c_IDX_W-1:0]    r_idx;
    logic [1:0]            r_lane;
    logic [DATA_WIDTH-1:0] r_hrdata;
    logic                  r_sleep_ack;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_addr_state;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_rd_load;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Only states that drive HREADYOUT high can take a new address phase.
    assign w_addr_state = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_accept     = i_hselx & i_htrans & i_hready & w_addr_state;

    assign w_err = (i_haddr[ADDR_WIDTH-1:2] >= c_MEM_WORDS)
                 | (i_hsize > 3'd2)
                 | ((i_hsize == 3'd1) & i_haddr[0])
                 | ((i_hsize == 3'd2) & (i_haddr[1:0] != 2'b00))
                 | r_sleep_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        case (r_state)
            S_WAIT: begin
                o_hreadyout = 1'b0;
                if (r_wcnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            S_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
                w_state_nxt = S_ERR2;
            end
            default: begin
                o_hresp = (r_state == S_ERR2);
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = c_WAIT_LOAD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // A read enters DONE either from the end of WAIT or straight from accept.
    always_comb begin
        w_rd_load = 1'b0;
        w_rd_idx  = r_idx;
        if (r_state == S_WAIT) begin
            w_rd_load = (r_wcnt == 4'd0) & ~r_hwrite;
        end else if (w_accept && !w_err && (WAIT_STATES == 0)) begin
            w_rd_load = ~i_hwrite;
            w_rd_idx  = i_haddr[c_IDX_W+1:2];
        end
    end

    always_comb begin
        case (r_hsize)
            3'd0:    w_be = 4'b0001 << r_lane;
            3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_commit = (r_state == S_DONE) & r_hwrite;

    // Merge write-in-flight bytes so a back-to-back read sees them.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_commit && (w_rd_idx == r_idx)) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    w_rd_word[8*k +: 8] = i_hwdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[r_idx][8*k +: 8] <= i_hwdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 4'd0;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'd0;
            r_idx       <= '0;
            r_lane      <= 2'd0;
            r_hrdata    <= '0;
            r_sleep_ack <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_hwrite <= i_hwrite;
                r_hsize  <= i_hsize;
                r_idx    <= i_haddr[c_IDX_W+1:2];
                r_lane   <= i_haddr[1:0];
            end
            if (w_rd_load) begin
                r_hrdata <= w_rd_word;
            end
            if (r_sleep_ack) begin
                if (!i_sleep_req) begin
                    r_sleep_ack <= 1'b0;
                end
            end else if (i_sleep_req && (r_state == S_IDLE) && !w_accept) begin
                r_sleep_ack <= 1'b1;
            end
        end
    end

    assign o_hrdata    = r_hrdata;
    assign o_sleep_ack = r_sleep_ack;

endmodule

`default_nettype wire
